// File: rtl/fetch_state_regs.sv
// ============================================================================
// Module   : fetch_state_regs
// Brief    : PC / IR / MDR state for the multicycle MIPS datapath, plus the
//            fetch counter and the sticky misaligned-PC flag.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_state_regs #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          CNT_W    = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             PCWrite,
   input  logic             Branch,
   input  logic             PCSrc,
   input  logic             IorD,
   input  logic             IRWrite,
   input  logic [31:0]      alu_result,
   input  logic [31:0]      alu_out,
   input  logic             alu_zero,
   input  logic [31:0]      mem_rdata,
   output logic [31:0]      mem_addr,
   output logic [31:0]      pc,
   output logic [31:0]      instr,
   output logic [5:0]       opcode,
   output logic [4:0]       rs,
   output logic [4:0]       rt,
   output logic [4:0]       rd,
   output logic [4:0]       shamt,
   output logic [5:0]       funct,
   output logic [15:0]      imm,
   output logic [31:0]      mdr,
   output logic [CNT_W-1:0] fetch_count,
   output logic             pc_misalign
);

   logic [31:0]      r_pc;
   logic [31:0]      r_instr;
   logic [31:0]      r_mdr;
   logic [CNT_W-1:0] r_fetch_count;
   logic             r_pc_misalign;

   logic             w_pc_en;
   logic [31:0]      w_pc_next;

   assign w_pc_en   = PCWrite | (Branch & alu_zero);
   assign w_pc_next = PCSrc ? alu_out : alu_result;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_pc          <= RESET_PC;
         r_instr       <= 32'h0000_0000;
         r_mdr         <= 32'h0000_0000;
         r_fetch_count <= '0;
         r_pc_misalign <= 1'b0;
      end else begin
         r_mdr <= mem_rdata;
         // The PC is kept word aligned; a misaligned target only raises the flag.
         if (w_pc_en) begin
            r_pc <= {w_pc_next[31:2], 2'b00};
            if (w_pc_next[1:0] != 2'b00)
               r_pc_misalign <= 1'b1;
         end
         if (IRWrite) begin
            r_instr       <= mem_rdata;
            r_fetch_count <= r_fetch_count + {{(CNT_W-1){1'b0}}, 1'b1};
         end
      end
   end

   assign mem_addr    = IorD ? alu_out : r_pc;
   assign pc          = r_pc;
   assign instr       = r_instr;
   assign mdr         = r_mdr;
   assign fetch_count = r_fetch_count;
   assign pc_misalign = r_pc_misalign;

   assign opcode = r_instr[31:26];
   assign rs     = r_instr[25:21];
   assign rt     = r_instr[20:16];
   assign rd     = r_instr[15:11];
   assign shamt  = r_instr[10:6];
   assign funct  = r_instr[5:0];
   assign imm    = r_instr[15:0];

endmodule

`default_nettype wire

// File: tb/tb_fetch_state_regs.sv
// ============================================================================
// Module   : tb_fetch_state_regs
// Brief    : Directed vectors feed an expectation queue; a monitor compares
//            the DUT state one clock edge after each vector is applied.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_state_regs;

   localparam int CNT_W = 4;

   logic             clk = 1'b0;
   logic             reset, PCWrite, Branch, PCSrc, IorD, IRWrite, alu_zero;
   logic [31:0]      alu_result, alu_out, mem_rdata;
   logic [31:0]      mem_addr, pc, instr, mdr;
   logic [5:0]       opcode, funct;
   logic [4:0]       rs, rt, rd, shamt;
   logic [15:0]      imm;
   logic [CNT_W-1:0] fetch_count;
   logic             pc_misalign;

   int total = 0;
   int bad   = 0;

   typedef struct {
      string            name;
      logic [31:0]      pc;
      logic [31:0]      instr;
      logic [31:0]      mdr;
      logic [31:0]      addr;
      logic [CNT_W-1:0] fc;
      logic             mis;
   } exp_t;

   exp_t sb[$];

   fetch_state_regs #(.RESET_PC(32'h0000_0000), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset), .PCWrite(PCWrite), .Branch(Branch),
      .PCSrc(PCSrc), .IorD(IorD), .IRWrite(IRWrite),
      .alu_result(alu_result), .alu_out(alu_out), .alu_zero(alu_zero),
      .mem_rdata(mem_rdata), .mem_addr(mem_addr), .pc(pc), .instr(instr),
      .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt),
      .funct(funct), .imm(imm), .mdr(mdr), .fetch_count(fetch_count),
      .pc_misalign(pc_misalign)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input string fld,
                      input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s.%s actual=%h required=%h", tag, fld, act, req);
      end
   endtask

   // Monitor: every expectation is checked just after the edge it refers to.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk(e.name, "pc",     pc,                  e.pc);
            chk(e.name, "instr",  instr,               e.instr);
            chk(e.name, "mdr",    mdr,                 e.mdr);
            chk(e.name, "addr",   mem_addr,            e.addr);
            chk(e.name, "fcount", 32'(fetch_count),    32'(e.fc));
            chk(e.name, "mis",    32'(pc_misalign),    32'(e.mis));
            chk(e.name, "opcode", 32'(opcode),         32'(e.instr[31:26]));
            chk(e.name, "rs",     32'(rs),             32'(e.instr[25:21]));
            chk(e.name, "rt",     32'(rt),             32'(e.instr[20:16]));
            chk(e.name, "rd",     32'(rd),             32'(e.instr[15:11]));
            chk(e.name, "shamt",  32'(shamt),          32'(e.instr[10:6]));
            chk(e.name, "funct",  32'(funct),          32'(e.instr[5:0]));
            chk(e.name, "imm",    32'(imm),            32'(e.instr[15:0]));
         end
      end
   end

   task automatic vec(input string name,
                      input logic rst, input logic irw, input logic pcw,
                      input logic br, input logic src, input logic iord,
                      input logic zero, input logic [31:0] ares,
                      input logic [31:0] aout, input logic [31:0] rdata,
                      input logic [31:0] e_pc, input logic [31:0] e_instr,
                      input logic [31:0] e_mdr, input logic [31:0] e_addr,
                      input logic [CNT_W-1:0] e_fc, input logic e_mis);
      exp_t e;
      @(negedge clk);
      reset = rst; IRWrite = irw; PCWrite = pcw; Branch = br; PCSrc = src;
      IorD = iord; alu_zero = zero; alu_result = ares; alu_out = aout;
      mem_rdata = rdata;
      e.name = name; e.pc = e_pc; e.instr = e_instr; e.mdr = e_mdr;
      e.addr = e_addr; e.fc = e_fc; e.mis = e_mis;
      sb.push_back(e);
   endtask

   initial begin
      int wait_cyc;
      logic [CNT_W-1:0] fc;
      reset = 1'b1; IRWrite = 0; PCWrite = 0; Branch = 0; PCSrc = 0; IorD = 0;
      alu_zero = 0; alu_result = 0; alu_out = 0; mem_rdata = 0;

      //   name        rst irw pcw br src iod z  alu_result    alu_out       rdata          pc            instr         mdr           addr         fc mis
      vec("reset",      1, 1, 1, 0, 0, 0, 0, 32'h0000_0010, 32'h0,        32'h0000_1234, 32'h0,        32'h0,        32'h0,        32'h0,        0, 0);
      vec("fetch",      0, 1, 1, 0, 0, 0, 0, 32'h0000_0004, 32'h0,        32'h012A_4020, 32'h4,        32'h012A_4020,32'h012A_4020,32'h4,        1, 0);
      vec("br_nt",      0, 0, 0, 1, 1, 0, 0, 32'h0,         32'h0000_0040,32'h0,         32'h4,        32'h012A_4020,32'h0,        32'h4,        1, 0);
      vec("br_t",       0, 0, 0, 1, 1, 0, 1, 32'h0,         32'h0000_0040,32'h0,         32'h40,       32'h012A_4020,32'h0,        32'h40,       1, 0);
      vec("data",       0, 0, 0, 0, 0, 1, 0, 32'h0,         32'h0000_0100,32'hDEAD_BEEF, 32'h40,       32'h012A_4020,32'hDEAD_BEEF,32'h100,      1, 0);
      vec("pcw_br",     0, 0, 1, 1, 1, 0, 0, 32'h0,         32'hFFFF_FFFC,32'h0,         32'hFFFF_FFFC,32'h012A_4020,32'h0,        32'hFFFF_FFFC,1, 0);
      vec("pc_wrap",    0, 0, 1, 0, 0, 0, 0, 32'h0,         32'h0,        32'h0,         32'h0,        32'h012A_4020,32'h0,        32'h0,        1, 0);
      vec("br_nt_mis",  0, 0, 0, 1, 1, 0, 0, 32'h0,         32'h0000_0002,32'h0,         32'h0,        32'h012A_4020,32'h0,        32'h0,        1, 0);
      vec("misalign",   0, 0, 1, 0, 0, 0, 0, 32'h0000_0006, 32'h0,        32'h0,         32'h4,        32'h012A_4020,32'h0,        32'h4,        1, 1);
      vec("sticky",     0, 0, 1, 0, 0, 0, 0, 32'h0000_0008, 32'h0,        32'h0,         32'h8,        32'h012A_4020,32'h0,        32'h8,        1, 1);

      // Fifteen more IR loads take the 4-bit counter from 1 through 15 and back to 0.
      fc = 4'd1;
      for (int i = 0; i < 15; i++) begin
         fc = fc + 4'd1;
         vec("count", 0, 1, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'hA000_0000 + i,
             32'h8, 32'hA000_0000 + i, 32'hA000_0000 + i, 32'h8, fc, 1);
      end

      vec("rst_data",   1, 1, 1, 0, 0, 1, 0, 32'h0000_0010, 32'h0000_0200,32'h0000_0055, 32'h0,        32'h0,        32'h0,        32'h200,      0, 0);
      vec("refetch",    0, 1, 1, 0, 0, 0, 0, 32'h0000_0004, 32'h0,        32'h0000_0020, 32'h4,        32'h0000_0020,32'h0000_0020,32'h4,        1, 0);

      wait_cyc = 0;
      while (sb.size() > 0 && wait_cyc < 20) begin
         @(posedge clk);
         wait_cyc++;
      end
      #2;
      total++;
      if (sb.size() != 0) begin
         bad++;
         $display("FAIL drain actual=%0d required=0 pending", sb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
